// File: rtl/milestone_scheduler.sv
// Top-level sequencer for the image decompressor: runs UART load, M2 (IDCT) and M1
// (upsample + CSC) in turn, muxes the shared SRAM port, and watches each stage for hangs.
module milestone_scheduler #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd10_000_000,
    parameter bit          SKIP_M2        = 1'b0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        go,
    output logic        uart_start,
    output logic        m2start,
    output logic        m1start,
    input  logic        uart_end,
    input  logic        m2end,
    input  logic        m1end,
    input  logic [17:0] uart_SRAM_address,
    input  logic [17:0] m2_SRAM_address,
    input  logic [17:0] m1_SRAM_address,
    input  logic [15:0] uart_SRAM_write_data,
    input  logic [15:0] m2_SRAM_write_data,
    input  logic [15:0] m1_SRAM_write_data,
    input  logic        uart_SRAM_we_n,
    input  logic        m2_SRAM_we_n,
    input  logic        m1_SRAM_we_n,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_stage,
    output logic [31:0] last_stage_cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_M2, S_M1, S_DONE, S_ERROR
    } state_t;

    state_t      state;
    logic [31:0] stage_cnt;
    logic        first_cycle;
    logic        stage_end;
    logic        end_ok;
    logic [1:0]  stage_code;

    // The start pulse marks the first cycle of a stage; end pulses on that cycle are dropped.
    assign first_cycle = uart_start | m2start | m1start;

    always_comb begin
        stage_end  = 1'b0;
        stage_code = 2'd0;
        case (state)
            S_LOAD: begin stage_end = uart_end; stage_code = 2'd1; end
            S_M2:   begin stage_end = m2end;    stage_code = 2'd2; end
            S_M1:   begin stage_end = m1end;    stage_code = 2'd3; end
            default: ;
        endcase
    end

    assign end_ok = stage_end & ~first_cycle;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state             <= S_IDLE;
            uart_start        <= 1'b0;
            m2start           <= 1'b0;
            m1start           <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
            error_stage       <= 2'd0;
            last_stage_cycles <= 32'd0;
            stage_cnt         <= 32'd0;
        end else begin
            uart_start <= 1'b0;
            m2start    <= 1'b0;
            m1start    <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (go) begin
                        state       <= S_LOAD;
                        uart_start  <= 1'b1;
                        stage_cnt   <= 32'd0;
                        error_stage <= 2'd0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                    end
                end
                S_LOAD, S_M2, S_M1: begin
                    // An accepted end pulse takes priority over a coincident timeout.
                    if (end_ok) begin
                        last_stage_cycles <= stage_cnt + 32'd1;
                        stage_cnt         <= 32'd0;
                        if (state == S_M1) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (state == S_LOAD && !SKIP_M2) begin
                            state   <= S_M2;
                            m2start <= 1'b1;
                        end else begin
                            state   <= S_M1;
                            m1start <= 1'b1;
                        end
                    end else if (stage_cnt == TIMEOUT_CYCLES - 32'd1) begin
                        state       <= S_ERROR;
                        error_stage <= stage_code;
                        busy        <= 1'b0;
                        error       <= 1'b1;
                    end else begin
                        stage_cnt <= stage_cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
        case (state)
            S_LOAD: begin
                SRAM_address    = uart_SRAM_address;
                SRAM_write_data = uart_SRAM_write_data;
                SRAM_we_n       = uart_SRAM_we_n;
            end
            S_M2: begin
                SRAM_address    = m2_SRAM_address;
                SRAM_write_data = m2_SRAM_write_data;
                SRAM_we_n       = m2_SRAM_we_n;
            end
            S_M1: begin
                SRAM_address    = m1_SRAM_address;
                SRAM_write_data = m1_SRAM_write_data;
                SRAM_we_n       = m1_SRAM_we_n;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_milestone_scheduler.sv
// Bench for milestone_scheduler: per-cycle vector tables for the normal and SKIP_M2
// sequences, plus hand sequences for timeout, ignored end pulses and mid-stage reset.
module tb_milestone_scheduler;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        go, uart_end, m2end, m1end;
    logic [17:0] uart_addr, m2_addr, m1_addr;
    logic [15:0] uart_wd, m2_wd, m1_wd;
    logic        uart_we, m2_we, m1_we;

    logic        us_a, m2s_a, m1s_a, busy_a, done_a, err_a, we_a;
    logic [17:0] addr_a;
    logic [15:0] wd_a;
    logic [1:0]  es_a;
    logic [31:0] last_a;
    logic        us_b, m2s_b, m1s_b, busy_b, done_b, err_b, we_b;
    logic [17:0] addr_b;
    logic [15:0] wd_b;
    logic [1:0]  es_b;
    logic [31:0] last_b;

    logic        use_b;
    int          total = 0;
    int          bad = 0;

    always #5 Clock = ~Clock;

    milestone_scheduler #(.TIMEOUT_CYCLES(32'd16), .SKIP_M2(1'b0)) dut_a (
        .Clock(Clock), .Reset(Reset), .go(go),
        .uart_start(us_a), .m2start(m2s_a), .m1start(m1s_a),
        .uart_end(uart_end), .m2end(m2end), .m1end(m1end),
        .uart_SRAM_address(uart_addr), .m2_SRAM_address(m2_addr), .m1_SRAM_address(m1_addr),
        .uart_SRAM_write_data(uart_wd), .m2_SRAM_write_data(m2_wd), .m1_SRAM_write_data(m1_wd),
        .uart_SRAM_we_n(uart_we), .m2_SRAM_we_n(m2_we), .m1_SRAM_we_n(m1_we),
        .SRAM_address(addr_a), .SRAM_write_data(wd_a), .SRAM_we_n(we_a),
        .busy(busy_a), .done(done_a), .error(err_a), .error_stage(es_a),
        .last_stage_cycles(last_a)
    );

    milestone_scheduler #(.TIMEOUT_CYCLES(32'd16), .SKIP_M2(1'b1)) dut_b (
        .Clock(Clock), .Reset(Reset), .go(go),
        .uart_start(us_b), .m2start(m2s_b), .m1start(m1s_b),
        .uart_end(uart_end), .m2end(m2end), .m1end(m1end),
        .uart_SRAM_address(uart_addr), .m2_SRAM_address(m2_addr), .m1_SRAM_address(m1_addr),
        .uart_SRAM_write_data(uart_wd), .m2_SRAM_write_data(m2_wd), .m1_SRAM_write_data(m1_wd),
        .uart_SRAM_we_n(uart_we), .m2_SRAM_we_n(m2_we), .m1_SRAM_we_n(m1_we),
        .SRAM_address(addr_b), .SRAM_write_data(wd_b), .SRAM_we_n(we_b),
        .busy(busy_b), .done(done_b), .error(err_b), .error_stage(es_b),
        .last_stage_cycles(last_b)
    );

    typedef struct {
        int          rpt;
        logic [3:0]  in;     // {go, uart_end, m2end, m1end}
        logic [2:0]  st;     // {uart_start, m2start, m1start}
        logic        busy;
        logic        done;
        logic [1:0]  sel;    // 0 none, 1 uart, 2 m2, 3 m1
        logic [31:0] last;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int rpt, logic [3:0] in, logic [2:0] st, logic busy,
                                logic done, logic [1:0] sel, logic [31:0] last);
        vec_t v;
        v.rpt = rpt; v.in = in; v.st = st; v.busy = busy;
        v.done = done; v.sel = sel; v.last = last;
        return v;
    endfunction

    task automatic drive(input logic [3:0] in);
        {go, uart_end, m2end, m1end} = in;
    endtask

    task automatic check_cycle(input string name, input logic [2:0] st, input logic busy,
                               input logic done, input logic err, input logic [1:0] es,
                               input logic [1:0] sel, input logic [31:0] last);
        logic [8:0]  exp_c, got_c;
        logic [34:0] exp_s, got_s;
        logic [31:0] got_l;
        case (sel)
            2'd1:    exp_s = {18'h00123, 16'h1111, 1'b0};
            2'd2:    exp_s = {18'h00456, 16'h2222, 1'b1};
            2'd3:    exp_s = {18'h00789, 16'h3333, 1'b0};
            default: exp_s = {18'h0, 16'h0, 1'b1};
        endcase
        exp_c = {st, busy, done, err, 1'b0, es};
        if (use_b) begin
            got_c = {us_b, m2s_b, m1s_b, busy_b, done_b, err_b, 1'b0, es_b};
            got_s = {addr_b, wd_b, we_b};
            got_l = last_b;
        end else begin
            got_c = {us_a, m2s_a, m1s_a, busy_a, done_a, err_a, 1'b0, es_a};
            got_s = {addr_a, wd_a, we_a};
            got_l = last_a;
        end
        total += 3;
        if (got_c !== exp_c) begin
            bad++;
            $display("FAIL %s ctrl {starts,busy,done,err,0,es}: got %b want %b", name, got_c, exp_c);
        end
        if (got_s !== exp_s) begin
            bad++;
            $display("FAIL %s sram {addr,data,we_n}: got %h want %h", name, got_s, exp_s);
        end
        if (got_l !== last) begin
            bad++;
            $display("FAIL %s last_stage_cycles: got %0d want %0d", name, got_l, last);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        drive(4'b0000);
        Reset = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Inputs are set and outputs checked at the negedge; each row covers rpt cycles.
    task automatic run_table(input string name);
        for (int r = 0; r < tbl.size(); r++) begin
            for (int k = 0; k < tbl[r].rpt; k++) begin
                drive(tbl[r].in);
                check_cycle($sformatf("%s[%0d.%0d]", name, r, k), tbl[r].st, tbl[r].busy,
                            tbl[r].done, 1'b0, 2'd0, tbl[r].sel, tbl[r].last);
                @(negedge Clock);
            end
        end
        drive(4'b0000);
        tbl.delete();
    endtask

    initial begin
        Reset = 1'b1;
        drive(4'b0000);
        uart_addr = 18'h00123; uart_wd = 16'h1111; uart_we = 1'b0;
        m2_addr   = 18'h00456; m2_wd   = 16'h2222; m2_we   = 1'b1;
        m1_addr   = 18'h00789; m1_wd   = 16'h3333; m1_we   = 1'b0;
        use_b = 1'b0;

        // Normal sequence: ends 5, 10, 7 cycles after the start pulses.
        do_reset();
        tbl.push_back(mk(1, 4'b0111, 3'b000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0101, 3'b000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0010, 3'b000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b1000, 3'b000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 3'b100, 1, 0, 1, 0));
        tbl.push_back(mk(4, 4'b0000, 3'b000, 1, 0, 1, 0));
        tbl.push_back(mk(1, 4'b0100, 3'b000, 1, 0, 1, 0));
        tbl.push_back(mk(1, 4'b0000, 3'b010, 1, 0, 2, 6));
        tbl.push_back(mk(9, 4'b0000, 3'b000, 1, 0, 2, 6));
        tbl.push_back(mk(1, 4'b0010, 3'b000, 1, 0, 2, 6));
        tbl.push_back(mk(1, 4'b0000, 3'b001, 1, 0, 3, 11));
        tbl.push_back(mk(6, 4'b0000, 3'b000, 1, 0, 3, 11));
        tbl.push_back(mk(1, 4'b0001, 3'b000, 1, 0, 3, 11));
        tbl.push_back(mk(2, 4'b0000, 3'b000, 0, 1, 0, 8));
        tbl.push_back(mk(1, 4'b0111, 3'b000, 0, 1, 0, 8));
        tbl.push_back(mk(1, 4'b0000, 3'b000, 0, 1, 0, 8));
        run_table("seq");

        // SKIP_M2 variant with the same load/M1 stimulus.
        use_b = 1'b1;
        do_reset();
        tbl.push_back(mk(1, 4'b1000, 3'b000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 3'b100, 1, 0, 1, 0));
        tbl.push_back(mk(4, 4'b0000, 3'b000, 1, 0, 1, 0));
        tbl.push_back(mk(1, 4'b0100, 3'b000, 1, 0, 1, 0));
        tbl.push_back(mk(1, 4'b0000, 3'b001, 1, 0, 3, 6));
        tbl.push_back(mk(6, 4'b0000, 3'b000, 1, 0, 3, 6));
        tbl.push_back(mk(1, 4'b0001, 3'b000, 1, 0, 3, 6));
        tbl.push_back(mk(2, 4'b0000, 3'b000, 0, 1, 0, 8));
        run_table("skip");
        use_b = 1'b0;

        // Watchdog: M2 never ends, error on the 17th cycle counting m2start as the first.
        do_reset();
        drive(4'b1000);
        @(negedge Clock);
        for (int c = 0; c < 2; c++) begin
            drive((c == 1) ? 4'b0100 : 4'b0000);
            check_cycle("to_load", (c == 0) ? 3'b100 : 3'b000, 1, 0, 0, 2'd0, 2'd1, 0);
            @(negedge Clock);
        end
        drive(4'b0000);
        for (int c = 0; c < 16; c++) begin
            check_cycle($sformatf("to_m2[%0d]", c), (c == 0) ? 3'b010 : 3'b000,
                        1, 0, 0, 2'd0, 2'd2, 2);
            @(negedge Clock);
        end
        check_cycle("to_error", 3'b000, 0, 0, 1, 2'd2, 2'd0, 2);
        drive(4'b1000);
        @(negedge Clock);
        drive(4'b0000);
        check_cycle("to_restart", 3'b100, 1, 0, 0, 2'd0, 2'd1, 2);

        // Stray and early end pulses, then m2end on the last legal cycle.
        do_reset();
        drive(4'b1000);
        @(negedge Clock);
        for (int c = 0; c < 2; c++) begin
            drive(4'b0100);
            check_cycle($sformatf("ign_load[%0d]", c), (c == 0) ? 3'b100 : 3'b000,
                        1, 0, 0, 2'd0, 2'd1, 0);
            @(negedge Clock);
        end
        for (int c = 0; c < 16; c++) begin
            drive({1'b0, (c == 2), (c == 0 || c == 15), (c == 1)});
            check_cycle($sformatf("ign_m2[%0d]", c), (c == 0) ? 3'b010 : 3'b000,
                        1, 0, 0, 2'd0, 2'd2, 2);
            @(negedge Clock);
        end
        drive(4'b0000);
        check_cycle("ign_m1_start", 3'b001, 1, 0, 0, 2'd0, 2'd3, 16);
        @(negedge Clock);
        check_cycle("ign_m1_run", 3'b000, 1, 0, 0, 2'd0, 2'd3, 16);

        // Reset in the middle of M1 while the stage is writing.
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check_cycle("rst_mid", 3'b000, 0, 0, 0, 2'd0, 2'd0, 0);
        drive(4'b0111);
        @(negedge Clock);
        drive(4'b0000);
        check_cycle("rst_idle", 3'b000, 0, 0, 0, 2'd0, 2'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
